// File: rtl/div_unit_if.sv
// Request/result bundle between the EX stage and the iterative divide unit.
// Handshake: a request is taken on a rising edge where valid_i=1, div_ctrl_i!=0,
// flush_i=0 and ready_o=1; valid_o is a one-cycle result pulse with no back-pressure.
interface div_unit_if;
    logic        valid_i;
    logic [3:0]  div_ctrl_i;
    logic [31:0] src1_i;
    logic [31:0] src2_i;
    logic        flush_i;
    logic        ready_o;
    logic        busy_o;
    logic        valid_o;
    logic [31:0] result_o;

    modport master (
        output valid_i, div_ctrl_i, src1_i, src2_i, flush_i,
        input  ready_o, busy_o, valid_o, result_o
    );

    modport slave (
        input  valid_i, div_ctrl_i, src1_i, src2_i, flush_i,
        output ready_o, busy_o, valid_o, result_o
    );
endinterface

// File: rtl/div_unit.sv
// Iterative RV32M divider (div, divu, rem, remu): restoring shift-subtract, one
// quotient bit per cycle, with divide-by-zero and signed overflow resolved at accept.
module div_unit (
    input  logic        clk_i,
    input  logic        rst_i,
    div_unit_if.slave   bus,
    output logic [1:0]  dbg_state_o
);
    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    logic [4:0]        cnt;
    logic [XLEN-1:0]   result_q;
    logic [XLEN-1:0]   divisor_q;
    logic [XLEN-1:0]   rem_q;
    logic [XLEN-1:0]   quo_q;
    logic              op_rem_q;
    logic              sign_q;
    logic              sign_r;

    // Request decode
    logic              accept;
    logic              is_signed;
    logic              is_rem;
    logic              div_zero;
    logic              overflow;
    logic [XLEN-1:0]   abs1;
    logic [XLEN-1:0]   abs2;

    // Datapath step
    logic [XLEN:0]     rem_shift;
    logic [XLEN:0]     trial;
    logic [XLEN-1:0]   rem_next;
    logic [XLEN-1:0]   quo_next;
    logic [XLEN-1:0]   final_res;

    assign accept    = (state == IDLE) && bus.valid_i && (bus.div_ctrl_i != 4'b0000) && !bus.flush_i;
    assign is_signed = bus.div_ctrl_i[0] | bus.div_ctrl_i[2];
    assign is_rem    = bus.div_ctrl_i[2] | bus.div_ctrl_i[3];
    assign div_zero  = (bus.src2_i == '0);
    assign overflow  = is_signed && (bus.src1_i == 32'h8000_0000) && (bus.src2_i == 32'hFFFF_FFFF);
    assign abs1      = (is_signed && bus.src1_i[XLEN-1]) ? (~bus.src1_i + 32'd1) : bus.src1_i;
    assign abs2      = (is_signed && bus.src2_i[XLEN-1]) ? (~bus.src2_i + 32'd1) : bus.src2_i;

    // The shifted remainder can reach 33 bits; the 33-bit difference still has a
    // valid sign bit because its true value lies strictly within +/-2^32.
    assign rem_shift = {rem_q, quo_q[XLEN-1]};
    assign trial     = rem_shift - {1'b0, divisor_q};
    assign rem_next  = trial[XLEN] ? rem_shift[XLEN-1:0] : trial[XLEN-1:0];
    assign quo_next  = {quo_q[XLEN-2:0], ~trial[XLEN]};

    always_comb begin
        final_res = quo_next;
        if (op_rem_q) begin
            final_res = sign_r ? (~rem_next + 32'd1) : rem_next;
        end else begin
            final_res = sign_q ? (~quo_next + 32'd1) : quo_next;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= IDLE;
            cnt       <= '0;
            result_q  <= '0;
            divisor_q <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            op_rem_q  <= 1'b0;
            sign_q    <= 1'b0;
            sign_r    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_rem_q  <= is_rem;
                        sign_q    <= bus.div_ctrl_i[0] & (bus.src1_i[XLEN-1] ^ bus.src2_i[XLEN-1]);
                        sign_r    <= bus.div_ctrl_i[2] & bus.src1_i[XLEN-1];
                        divisor_q <= abs2;
                        quo_q     <= abs1;
                        rem_q     <= '0;
                        cnt       <= '0;
                        if (div_zero) begin
                            result_q <= is_rem ? bus.src1_i : '1;
                            state    <= DONE;
                        end else if (overflow) begin
                            result_q <= is_rem ? '0 : 32'h8000_0000;
                            state    <= DONE;
                        end else begin
                            state    <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (bus.flush_i) begin
                        state <= IDLE;
                    end else begin
                        rem_q <= rem_next;
                        quo_q <= quo_next;
                        cnt   <= cnt + 5'd1;
                        if (cnt == 5'(XLEN - 1)) begin
                            result_q <= final_res;
                            state    <= DONE;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.ready_o  = (state == IDLE);
    assign bus.busy_o   = accept || (state == CALC);
    assign bus.valid_o  = (state == DONE) && !bus.flush_i;
    assign bus.result_o = result_q;
    assign dbg_state_o  = state;
endmodule
